pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, which is the byte address loaded into the PC on reset.
REQ-002 The block SHALL have the parameter EXC_VECTOR, default 32'h0000_4180, which is the byte address of the exception handler entry.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have the port stall, input, 1 bit: hold the PC this cycle.
REQ-006 The block SHALL have the port npc_op, input, 2 bits: next-PC select (00 sequential, 01 branch, 10 jump, 11 jump-register).
REQ-007 The block SHALL have the port br_taken, input, 1 bit: branch condition result, used only when npc_op=01.
REQ-008 The block SHALL have the port imm16, input, 16 bits: branch offset in words.
REQ-009 The block SHALL have the port target26, input, 26 bits: jump target in words.
REQ-010 The block SHALL have the port rs_val, input, 32 bits: jump-register target byte address.
REQ-011 The block SHALL have the port exc_req, input, 1 bit: exception or interrupt request.
REQ-012 The block SHALL have the port eret, input, 1 bit: return-from-exception request.
REQ-013 The block SHALL have the port addr, output, 30 bits [31:2]: registered word address of the current instruction, driving the instruction memory address.
REQ-014 The block SHALL have the port pc4, output, 32 bits: combinational {addr,2'b00}+4.
REQ-015 The block SHALL have the port epc, output, 32 bits: registered exception return byte address.
REQ-016 The block SHALL have the port exl, output, 1 bit: registered exception-level flag.

Function
REQ-017 The PC register SHALL be 30 bits wide and hold a word address; the byte PC is {addr,2'b00}.
REQ-018 The block SHALL evaluate next-state once per rising edge with priority rst > exc_req (when exl=0) > eret (when exl=1) > stall > npc_op.
REQ-019 On an exception (exc_req=1 and exl=0), the block SHALL set epc to the current byte PC, addr to EXC_VECTOR[31:2], and exl to 1, regardless of stall.
REQ-020 The block SHALL ignore exc_req while exl=1, with no effect on addr, epc or exl.
REQ-021 On eret=1 with exl=1, the block SHALL set addr to epc[31:2] and clear exl, regardless of stall; eret with exl=0 SHALL be treated as no request.
REQ-022 When exc_req and eret are both asserted with exl=1, eret SHALL win and exc_req SHALL be ignored.
REQ-023 When stall=1 and no exception or eret is taken, addr, epc and exl SHALL hold their values.
REQ-024 For npc_op=00, the next addr SHALL be pc4[31:2].
REQ-025 For npc_op=01 with br_taken=1, the next addr SHALL be pc4[31:2] + sign_extend_30(imm16); with br_taken=0, it SHALL be pc4[31:2].
REQ-026 For npc_op=10, the next addr SHALL be {pc4[31:28], target26}.
REQ-027 For npc_op=11, the next addr SHALL be rs_val[31:2], with rs_val[1:0] ignored.
REQ-028 All address arithmetic SHALL be modulo 2^30 words, so 0x3FFF_FFFF + 1 wraps to 0.
REQ-029 The next PC SHALL take effect one cycle after the request, since outputs are registered and there is no combinational path from inputs to addr.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set addr to RESET_PC[31:2] (0), epc to 0 and exl to 0, overriding all other inputs.
REQ-031 Reset asserted mid-exception or mid-stall SHALL discard the pending state; the first instruction after reset release SHALL be at RESET_PC.

Verification
REQ-032 The bench SHALL cover reset then 4 cycles of npc_op=00 -> addr sequence 0,1,2,3,4 (byte PC 0x0,0x4,0x8,0xC,0x10).
REQ-033 The bench SHALL cover addr=0x00C (byte PC 0x30), npc_op=01, br_taken=1, imm16=0xFFFB -> next addr 0x008 (byte PC 0x20); the same with br_taken=0 -> addr 0x00D.
REQ-034 The bench SHALL cover byte PC 0x1000_0010 with npc_op=10 and target26=0x000_0040, giving byte PC 0x1000_0100; then npc_op=11 with rs_val=0x0000_0203, giving byte PC 0x0000_0200.
REQ-035 The bench SHALL cover byte PC 0x24 with exc_req=1 and stall=1 -> addr=0x1060 (byte PC 0x4180), epc=0x24, exl=1; then exc_req=1 again, giving no change to epc.
REQ-036 The bench SHALL cover exl=1, epc=0x24, with eret and exc_req both asserted -> byte PC 0x24, exl=0; then eret with exl=0 -> behaviour as npc_op.
REQ-037 The bench SHALL cover addr=0x3FFF_FFFF with npc_op=00, giving addr 0; stall=1 for 3 cycles, giving addr held; rst=1 during stall, giving addr=0, epc=0, exl=0.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter for a MIPS-style core. Holds the word address of the
//   current instruction and selects the next one from the sequential,
//   branch, jump and jump-register paths. Also tracks a single level of
//   exception state: the return address (epc) and the exception-level flag
//   (exl).
//
// Parameters
//   RESET_PC   : byte address loaded into the PC on reset
//   EXC_VECTOR : byte address of the exception handler entry
//
// Ports
//   clk      in   1  : clock, all state changes on the rising edge
//   rst      in   1  : synchronous active-high reset
//   stall    in   1  : hold PC, epc and exl this cycle
//   npc_op   in   2  : next-PC select (00 seq, 01 branch, 10 jump, 11 jr)
//   br_taken in   1  : branch condition, used only when npc_op = 01
//   imm16    in  16  : signed branch offset in words
//   target26 in  26  : jump target in words
//   rs_val   in  32  : jump-register target byte address
//   exc_req  in   1  : exception or interrupt request
//   eret     in   1  : return-from-exception request
//   addr     out 30  : registered word address of the current instruction
//   pc4      out 32  : byte PC + 4 (combinational)
//   epc      out 32  : registered exception return byte address
//   exl      out  1  : registered exception-level flag
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic        eret,
  output logic [29:0] addr,
  output logic [31:0] pc4,
  output logic [31:0] epc,
  output logic        exl
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  logic [29:0] addr_q, addr_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;

  logic [29:0] seqAddr;
  logic [29:0] brAddr;
  logic [29:0] jumpAddr;
  logic [29:0] jrAddr;
  logic [29:0] npcAddr;
  logic        takeExc;
  logic        takeEret;
  npc_op_e     npcSel;

  // Byte PC + 4; the 32-bit add wraps naturally so the top word rolls to 0.
  assign pc4 = {addr_q, 2'b00} + 32'd4;

  // Candidate word addresses for each next-PC source. All sums are 30 bits
  // wide, which gives the modulo 2^30 word arithmetic for free.
  assign seqAddr  = pc4[31:2];
  assign brAddr   = pc4[31:2] + {{14{imm16[15]}}, imm16};
  assign jumpAddr = {pc4[31:28], target26};
  assign jrAddr   = rs_val[31:2];

  // Exceptions are only taken outside the handler; eret only inside it.
  // Because the two conditions depend on opposite exl values, eret wins
  // automatically whenever both requests are raised while exl is set.
  assign takeExc  = exc_req & ~exl_q;
  assign takeEret = eret & exl_q;

  assign npcSel = npc_op_e'(npc_op);

  // Normal next-PC mux, used when no exception, eret or stall intervenes.
  always_comb begin
    npcAddr = seqAddr;
    unique case (npcSel)
      NPC_SEQ:    npcAddr = seqAddr;
      NPC_BRANCH: npcAddr = br_taken ? brAddr : seqAddr;
      NPC_JUMP:   npcAddr = jumpAddr;
      NPC_JR:     npcAddr = jrAddr;
      default:    npcAddr = seqAddr;
    endcase
  end

  // Next-state selection: exception entry, exception return, stall, then
  // the ordinary next-PC path. Reset is applied in the register process.
  always_comb begin
    addr_d = addr_q;
    epc_d  = epc_q;
    exl_d  = exl_q;
    if (takeExc) begin
      epc_d  = {addr_q, 2'b00};
      addr_d = EXC_VECTOR[31:2];
      exl_d  = 1'b1;
    end else if (takeEret) begin
      addr_d = epc_q[31:2];
      exl_d  = 1'b0;
    end else if (!stall) begin
      addr_d = npcAddr;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= RESET_PC[31:2];
      epc_q  <= 32'h0000_0000;
      exl_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      epc_q  <= epc_d;
      exl_q  <= exl_d;
    end
  end

  assign addr = addr_q;
  assign epc  = epc_q;
  assign exl  = exl_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Self-checking bench for pc_unit. A byte-address reference model tracks
//   the PC, epc and exl from the architectural rules; directed scenarios are
//   followed by a randomized run, each cycle checked against the model.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  npcOp;
  logic        brTaken;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rsVal;
  logic        excReq;
  logic        eret;
  logic [29:0] addr;
  logic [31:0] pc4;
  logic [31:0] epc;
  logic        exl;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state, kept as byte addresses.
  logic [31:0] mPc  = 32'h0;
  logic [31:0] mEpc = 32'h0;
  logic        mExl = 1'b0;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  pc_unit #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .npc_op  (npcOp),
    .br_taken(brTaken),
    .imm16   (imm16),
    .target26(target26),
    .rs_val  (rsVal),
    .exc_req (excReq),
    .eret    (eret),
    .addr    (addr),
    .pc4     (pc4),
    .epc     (epc),
    .exl     (exl)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance the reference model by one clock using the current inputs.
  task automatic modelStep();
    logic [31:0] nextPc;
    int signed   offset;
    nextPc = mPc + 32'd4;
    if (rst) begin
      mPc  = RESET_PC & 32'hFFFF_FFFC;
      mEpc = 32'h0;
      mExl = 1'b0;
    end else if (excReq && !mExl) begin
      mEpc = mPc;
      mPc  = EXC_VECTOR & 32'hFFFF_FFFC;
      mExl = 1'b1;
    end else if (eret && mExl) begin
      mPc  = mEpc & 32'hFFFF_FFFC;
      mExl = 1'b0;
    end else if (!stall) begin
      case (npcOp)
        2'd0: mPc = mPc + 32'd4;
        2'd1: begin
          offset = int'($signed(imm16));
          mPc = brTaken ? (mPc + 32'd4 + 32'(offset * 4)) : (mPc + 32'd4);
        end
        2'd2: mPc = (nextPc & 32'hF000_0000) | (32'(target26) * 32'd4);
        default: mPc = rsVal & 32'hFFFF_FFFC;
      endcase
    end
  endtask

  // One compare with counting and reporting.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkModel(input string tag);
    checkOutput({tag, ".addr"}, {2'b00, addr}, {2'b00, mPc[31:2]});
    checkOutput({tag, ".pc4"},  pc4, mPc + 32'd4);
    checkOutput({tag, ".epc"},  epc, mEpc);
    checkOutput({tag, ".exl"},  {31'd0, exl}, {31'd0, mExl});
  endtask

  // Drive one cycle of inputs, clock it, update the model, then settle.
  task automatic applyStimulus(input logic r, input logic s,
                               input logic [1:0] op, input logic bt,
                               input logic [15:0] imm, input logic [25:0] tgt,
                               input logic [31:0] rs, input logic exc,
                               input logic er);
    rst = r; stall = s; npcOp = op; brTaken = bt; imm16 = imm;
    target26 = tgt; rsVal = rs; excReq = exc; eret = er;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Shorthands for the common directed cases.
  task automatic seqStep(input logic s);
    applyStimulus(1'b0, s, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jrStep(input logic [31:0] rs);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, rs, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then four sequential fetches.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("resetAddr", {2'b00, addr}, 32'h0);
    checkOutput("resetEpc", epc, 32'h0);
    checkOutput("resetExl", {31'd0, exl}, 32'h0);
    checkModel("reset");
    for (int i = 1; i <= 4; i++) begin
      seqStep(1'b0);
      checkOutput("seqAddr", {2'b00, addr}, 32'(i));
      checkModel("seq");
    end

    // Branch taken backwards from byte PC 0x30, then not taken.
    jrStep(32'h0000_0030);
    checkOutput("toBranch", {2'b00, addr}, 32'h00C);
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFB, 26'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("brTaken", {2'b00, addr}, 32'h008);
    checkModel("brTaken");
    jrStep(32'h0000_0030);
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFB, 26'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("brNotTaken", {2'b00, addr}, 32'h00D);
    checkModel("brNotTaken");

    // Jump keeps the upper region; jr drops the low byte bits.
    jrStep(32'h1000_0010);
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h000_0040, 32'h0, 1'b0, 1'b0);
    checkOutput("jump", {addr, 2'b00}, 32'h1000_0100);
    checkModel("jump");
    jrStep(32'h0000_0203);
    checkOutput("jr", {addr, 2'b00}, 32'h0000_0200);
    checkModel("jr");

    // Exception taken despite stall, then a repeat request is ignored.
    jrStep(32'h0000_0024);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("excAddr", {2'b00, addr}, 32'h1060);
    checkOutput("excEpc", epc, 32'h24);
    checkOutput("excExl", {31'd0, exl}, 32'h1);
    checkModel("exc");
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("excAgainEpc", epc, 32'h24);
    checkOutput("excAgainAddr", {2'b00, addr}, 32'h1061);
    checkModel("excAgain");

    // eret beats a simultaneous exception; eret outside the handler is inert.
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
    checkOutput("eretPc", {addr, 2'b00}, 32'h24);
    checkOutput("eretExl", {31'd0, exl}, 32'h0);
    checkModel("eret");
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("eretIdle", {addr, 2'b00}, 32'h28);
    checkModel("eretIdle");

    // Top-of-memory wrap, stall hold, then reset during stall.
    jrStep(32'hFFFF_FFFC);
    checkOutput("topAddr", {2'b00, addr}, 32'h3FFF_FFFF);
    seqStep(1'b0);
    checkOutput("wrapAddr", {2'b00, addr}, 32'h0);
    checkModel("wrap");
    seqStep(1'b0);
    for (int i = 0; i < 3; i++) begin
      seqStep(1'b1);
      checkOutput("stallHold", {2'b00, addr}, 32'h1);
      checkModel("stall");
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("rstAddr", {2'b00, addr}, 32'h0);
    checkOutput("rstEpc", epc, 32'h0);
    checkOutput("rstExl", {31'd0, exl}, 32'h0);
    checkModel("rstStall");

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    16'($urandom),
                    26'($urandom),
                    $urandom,
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 4) == 0));
      checkModel("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
